// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, fetches 32-bit MIPS words over a
// req/ack handshake, latches them into the IR and presents decoded fields.
// A redirect that arrives while a request is outstanding cannot cancel
// that request. The stage finishes it in FLUSH and then throws the data away.

module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ir_valid,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [5:0]        func,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0] pcout_q, pcout_d;
    logic [31:0]       ir_q, ir_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] target;
    logic              fetchReq;
    logic              redirect_lsb_unused;

    // Redirect targets are always word aligned; the low address bits are dropped.
    assign target              = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // The fetch request is withheld only when a valid IR is being held by stall.
    assign fetchReq = ~(valid_q & stall);

    // Next-state logic: sequencing, PC update and IR capture per state.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pend_d   = pend_q;
        pcout_d  = pcout_q;
        ir_d     = ir_q;
        valid_d  = valid_q;
        imem_req = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) begin
                    pc_d    = target;
                    ir_d    = '0;
                    valid_d = 1'b0;
                end
            end

            FETCH: begin
                imem_req = fetchReq;
                if (redirect) begin
                    ir_d    = '0;
                    valid_d = 1'b0;
                    if (fetchReq && !imem_ack) begin
                        pend_d  = target;
                        state_d = FLUSH;
                    end else begin
                        pc_d    = target;
                        state_d = FETCH;
                    end
                end else if (!fetchReq) begin
                    state_d = STALL;
                end else if (imem_ack) begin
                    ir_d    = imem_rdata;
                    valid_d = 1'b1;
                    pcout_d = pc_q;
                    pc_d    = pc_q + ADDR_W'(4);
                end
            end

            STALL: begin
                if (redirect) begin
                    pc_d    = target;
                    ir_d    = '0;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall || !valid_q) begin
                    state_d = FETCH;
                end
            end

            FLUSH: begin
                imem_req = 1'b1;
                if (redirect) begin
                    pend_d = target;
                end
                if (imem_ack) begin
                    pc_d    = redirect ? target : pend_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            pcout_q <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            pcout_q <= pcout_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign ir_valid  = valid_q;
    assign op        = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign func      = ir_q[5:0];
    assign imm       = ir_q[15:0];
    assign pc_out    = pcout_q;
    assign pc_plus4  = pcout_q + ADDR_W'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Every accepted fetch pushes the
// expected {pc, instruction} pair, and a monitor pops and checks the IR load.
// Scenario tasks check the handshake, stall, redirect and reset behaviour inline.

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ir_valid;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  func;
    logic [15:0] imm;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    int          vectors     = 0;
    int          miscompares = 0;

    logic [63:0] expQ[$];
    logic [31:0] expPc   = 32'h0;
    logic        loadExp = 1'b0;
    logic        reqSeen;
    logic [31:0] addrSeen;

    logic [63:0] sbEntry;
    logic [31:0] sbPc;
    logic [31:0] sbIr;
    logic [31:0] sbPlus;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir_valid    (ir_valid),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .func        (func),
        .imm         (imm),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Instruction memory contents: two fixed words, then an address-unique pattern.
    function automatic logic [31:0] instrAt(input logic [31:0] a);
        if (a == 32'h0)      return 32'h00221820;
        else if (a == 32'h4) return 32'h8C430004;
        else                 return {6'h08, a[27:2]};
    endfunction

    // One clock of stimulus: inputs driven at the falling edge, request sampled,
    // an expected IR load queued if the cycle should complete a fetch.
    task automatic tick(input logic ack, input logic stl, input logic redir,
                        input logic [31:0] tgt, input logic expectLoad);
        @(negedge clk);
        imem_ack    = ack;
        stall       = stl;
        redirect    = redir;
        redirect_pc = tgt;
        #1;
        imem_rdata = instrAt(imem_addr);
        reqSeen    = imem_req;
        addrSeen   = imem_addr;
        if (expectLoad) begin
            expQ.push_back({expPc, instrAt(expPc)});
            expPc = expPc + 32'd4;
        end
        loadExp = expectLoad;
        @(posedge clk);
        #2;
        loadExp  = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b0;
    endtask

    // Scoreboard monitor: after every edge that should load the IR, compare against the queue head.
    always @(posedge clk) begin
        if (loadExp) begin
            #1;
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL sb_empty: load observed with no expected entry");
            end else begin
                sbEntry = expQ.pop_front();
                sbPc    = sbEntry[63:32];
                sbIr    = sbEntry[31:0];
                sbPlus  = sbPc + 32'd4;
                vectors++;
                if (ir_valid !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL sb_valid: got %b expected 1", ir_valid);
                end
                vectors++;
                if ({op, rs, rt, imm} !== sbIr) begin
                    miscompares++;
                    $display("[TB] FAIL sb_ir: got %h expected %h", {op, rs, rt, imm}, sbIr);
                end
                vectors++;
                if ({rd, func} !== {sbIr[15:11], sbIr[5:0]}) begin
                    miscompares++;
                    $display("[TB] FAIL sb_rd_func: got %h expected %h", {rd, func}, {sbIr[15:11], sbIr[5:0]});
                end
                vectors++;
                if (pc_out !== sbPc) begin
                    miscompares++;
                    $display("[TB] FAIL sb_pc_out: got %h expected %h", pc_out, sbPc);
                end
                vectors++;
                if (pc_plus4 !== sbPlus) begin
                    miscompares++;
                    $display("[TB] FAIL sb_pc_plus4: got %h expected %h", pc_plus4, sbPlus);
                end
            end
        end
    end

    task automatic test_reset();
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        vectors++;
        if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", ir_valid); end
        vectors++;
        if ({op, func} !== 12'h0) begin miscompares++; $display("[TB] FAIL reset_nop: got %h expected 000", {op, func}); end
        vectors++;
        if (pc_out !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc_out: got %h expected 0", pc_out); end
        vectors++;
        if (pc_plus4 !== 32'h4) begin miscompares++; $display("[TB] FAIL reset_pc_plus4: got %h expected 4", pc_plus4); end
        reset = 1'b0;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_req: got %b expected 0", imem_req); end
        expPc = 32'h0;
    endtask

    task automatic test_fill();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (reqSeen !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_req: got %b expected 1", reqSeen); end
        vectors++;
        if (addrSeen !== 32'h0) begin miscompares++; $display("[TB] FAIL fill_addr0: got %h expected 0", addrSeen); end
        vectors++;
        if ({op, func} !== {6'h00, 6'h20}) begin miscompares++; $display("[TB] FAIL fill_op_func0: got %h expected 020", {op, func}); end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addrSeen !== 32'h4) begin miscompares++; $display("[TB] FAIL fill_addr4: got %h expected 4", addrSeen); end
        vectors++;
        if (op !== 6'h23) begin miscompares++; $display("[TB] FAIL fill_op1: got %h expected 23", op); end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (reqSeen !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_req[%0d]: got %b expected 0", i, reqSeen); end
            vectors++;
            if (pc_out !== 32'hC) begin miscompares++; $display("[TB] FAIL stall_pc_out[%0d]: got %h expected c", i, pc_out); end
            vectors++;
            if ({op, rs, rt, imm} !== instrAt(32'hC)) begin
                miscompares++;
                $display("[TB] FAIL stall_ir[%0d]: got %h expected %h", i, {op, rs, rt, imm}, instrAt(32'hC));
            end
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (reqSeen !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_release_req: got %b expected 0", reqSeen); end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addrSeen !== 32'h10) begin miscompares++; $display("[TB] FAIL stall_resume_addr: got %h expected 10", addrSeen); end
    endtask

    task automatic test_slow_ack();
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (reqSeen !== 1'b1) begin miscompares++; $display("[TB] FAIL slow_req[%0d]: got %b expected 1", i, reqSeen); end
            vectors++;
            if (addrSeen !== 32'h14) begin miscompares++; $display("[TB] FAIL slow_addr[%0d]: got %h expected 14", i, addrSeen); end
            vectors++;
            if (pc_out !== 32'h10) begin miscompares++; $display("[TB] FAIL slow_pc_out[%0d]: got %h expected 10", i, pc_out); end
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addrSeen !== 32'h14) begin miscompares++; $display("[TB] FAIL slow_ack_addr: got %h expected 14", addrSeen); end
    endtask

    task automatic test_redirect_pending();
        tick(1'b0, 1'b0, 1'b1, 32'h103, 1'b0);
        vectors++;
        if (addrSeen !== 32'h18) begin miscompares++; $display("[TB] FAIL redir_req_addr: got %h expected 18", addrSeen); end
        vectors++;
        if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_valid: got %b expected 0", ir_valid); end
        vectors++;
        if ({op, rs, rt, imm} !== 32'h0) begin miscompares++; $display("[TB] FAIL redir_ir_clear: got %h expected 0", {op, rs, rt, imm}); end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({reqSeen, addrSeen} !== {1'b1, 32'h18}) begin
            miscompares++;
            $display("[TB] FAIL flush_hold: got req %b addr %h expected 1 / 18", reqSeen, addrSeen);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({reqSeen, addrSeen} !== {1'b1, 32'h18}) begin
            miscompares++;
            $display("[TB] FAIL flush_ack: got req %b addr %h expected 1 / 18", reqSeen, addrSeen);
        end
        vectors++;
        if ({ir_valid, op, rs, rt, imm} !== 33'h0) begin
            miscompares++;
            $display("[TB] FAIL flush_discard: got valid %b ir %h expected 0 / 0", ir_valid, {op, rs, rt, imm});
        end
        expPc = 32'h100;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addrSeen !== 32'h100) begin miscompares++; $display("[TB] FAIL flush_target_addr: got %h expected 100", addrSeen); end
        tick(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 32'h82, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if (addrSeen !== 32'h104) begin miscompares++; $display("[TB] FAIL flush2_old_addr: got %h expected 104", addrSeen); end
        expPc = 32'h80;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addrSeen !== 32'h80) begin miscompares++; $display("[TB] FAIL flush_latest_wins: got %h expected 80", addrSeen); end
    endtask

    task automatic test_redirect_on_ack();
        tick(1'b1, 1'b0, 1'b1, 32'h300, 1'b0);
        vectors++;
        if (addrSeen !== 32'h84) begin miscompares++; $display("[TB] FAIL ack_redir_addr: got %h expected 84", addrSeen); end
        vectors++;
        if ({ir_valid, op, rs, rt, imm} !== 33'h0) begin
            miscompares++;
            $display("[TB] FAIL ack_redir_drop: got valid %b ir %h expected 0 / 0", ir_valid, {op, rs, rt, imm});
        end
        tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({reqSeen, addrSeen} !== {1'b1, 32'h300}) begin
            miscompares++;
            $display("[TB] FAIL ack_redir_next: got req %b addr %h expected 1 / 300", reqSeen, addrSeen);
        end
        expPc = 32'h300;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        tick(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        expPc = 32'hFFFF_FFFC;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addrSeen !== 32'hFFFF_FFFC) begin miscompares++; $display("[TB] FAIL wrap_addr: got %h expected fffffffc", addrSeen); end
        vectors++;
        if (pc_plus4 !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_pc_plus4: got %h expected 0", pc_plus4); end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addrSeen !== 32'h0) begin miscompares++; $display("[TB] FAIL wrap_pc: got %h expected 0", addrSeen); end
    endtask

    task automatic test_reset_in_flush();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 32'h500, 1'b0);
        @(negedge clk);
        #1;
        vectors++;
        if (imem_req !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_flush_req: got %b expected 1", imem_req); end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_req: got %b expected 0", imem_req); end
        vectors++;
        if (ir_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async_reset_valid: got %b expected 0", ir_valid); end
        vectors++;
        if (pc_out !== 32'h0) begin miscompares++; $display("[TB] FAIL async_reset_pc_out: got %h expected 0", pc_out); end
        vectors++;
        if (pc_plus4 !== 32'h4) begin miscompares++; $display("[TB] FAIL async_reset_pc_plus4: got %h expected 4", pc_plus4); end
        vectors++;
        if ({op, func} !== 12'h0) begin miscompares++; $display("[TB] FAIL async_reset_nop: got %h expected 000", {op, func}); end
        @(negedge clk);
        reset = 1'b0;
        expPc = 32'h0;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        vectors++;
        if (addrSeen !== 32'h0) begin miscompares++; $display("[TB] FAIL post_reset_addr: got %h expected 0", addrSeen); end
        vectors++;
        if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL sb_leftover: got %0d entries expected 0", expQ.size()); end
    endtask

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_slow_ack();
        test_redirect_pending();
        test_redirect_on_ack();
        test_wrap();
        test_reset_in_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a run that never reaches its summary.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the controller.
- Holds the PC and fetches 32-bit MIPS instructions from instruction memory over a req/ack handshake.
- Latches each instruction into an instruction register (IR) and presents decoded fields (op, func, rs, rt, rd, imm) to the controller and datapath.
- Supports downstream stall and branch/jump redirect with flush of in-flight fetches.

Parameters:
ADDR_W, 32, PC / instruction address width
RESET_PC, 0, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request; held with stable imem_addr until imem_ack
imem_addr  output  ADDR_W  fetch address
imem_ack  input  1  memory returns imem_rdata this cycle; only meaningful while imem_req=1
imem_rdata  input  32  instruction word
stall  input  1  downstream hold; IR must not change while stall=1 and ir_valid=1
redirect  input  1  branch/jump taken; one-cycle pulse
redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored, forced to 0
ir_valid  output  1  IR holds a valid instruction
op  output  6  IR[31:26]
rs  output  5  IR[25:21]
rt  output  5  IR[20:16]
rd  output  5  IR[15:11]
func  output  6  IR[5:0]
imm  output  16  IR[15:0]
pc_out  output  ADDR_W  address of the instruction in IR
pc_plus4  output  ADDR_W  pc_out + 4, modulo 2^ADDR_W

Behaviour:
- Reset (async, any state):
  - pc = RESET_PC, IR = 0, ir_valid = 0, pc_out = 0, imem_req = 0.
  - State = IDLE.
  - IR = 0 presents op = 0 / func = 0 (NOP to the controller).
- States: IDLE, FETCH, STALL, FLUSH.
- IDLE:
  - imem_req = 0.
  - Next cycle -> FETCH unconditionally. Redirect in IDLE loads pc.
- FETCH:
  - imem_addr = pc.
  - imem_req = 1 unless (ir_valid && stall); in that case imem_req = 0 that cycle and next state = STALL.
  - On imem_req && imem_ack: IR <= imem_rdata, ir_valid <= 1, pc_out <= pc, pc <= pc + 4 (wraps at 2^ADDR_W).
  - With single-cycle ack, throughput is one instruction per clock.
  - Fetch-to-IR latency: ack cycle + 1 edge.
- STALL:
  - imem_req = 0; IR, pc and pc_out held.
  - stall=0 -> FETCH.
  - stall with ir_valid=0 never holds.
- Redirect (priority over stall and ack; below reset):
  - Next edge: ir_valid <= 0, IR <= 0, pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Redirect in FETCH with imem_req=1 and no ack same cycle:
    - The request is already committed: keep imem_req=1 with the old address.
    - Store the target in a pending register; state -> FLUSH.
  - Redirect coinciding with imem_ack: discard imem_rdata, load target into pc, -> FETCH.
  - Redirect in IDLE/STALL: load pc, -> FETCH.
- FLUSH:
  - imem_req = 1 at the old address until ack.
  - Returned data is discarded (IR stays 0, ir_valid stays 0).
  - On ack: pc <= pending target, -> FETCH.
  - A further redirect during FLUSH overwrites the pending target (latest wins).
  - stall is ignored in FLUSH.
- imem_addr must never change while imem_req=1 and imem_ack=0.
- Field outputs, pc_out and pc_plus4 are registered/derived from IR and pc_out only, with no combinational path from imem_rdata.

Test Plan:
- Reset, then imem_ack tied 1, rdata = 0x00221820 at 0x0 and 0x8C430004 at 0x4:
  - IR fills on consecutive edges; op=0/func=0x20 then op=0x23.
  - pc_out = 0x0 then 0x4; pc_plus4 = 0x4 then 0x8.
- Stall asserted 3 cycles with ir_valid=1:
  - imem_req=0 throughout; IR and pc_out unchanged.
  - Fetch at the held pc resumes the cycle after stall drops; no instruction is skipped or duplicated.
- imem_ack delayed 4 cycles: imem_req and imem_addr stay constant; IR loads only on the ack cycle.
- Redirect to 0x103 while a request is pending without ack:
  - FLUSH is entered; the old-address data is discarded, ir_valid = 0.
  - Next fetch address is 0x100.
- Redirect on the same cycle as imem_ack: data dropped, next imem_addr = target, ir_valid = 0.
- Redirect to 0xFFFFFFFC, ack every cycle: after that fetch, pc wraps to 0x0; pc_plus4 = 0x0. Async reset mid-FLUSH returns all outputs to reset values immediately.
